// File: rtl/minmax_pkg.sv
// Shared types and constants for the min/max scan engine.
package minmax_pkg;

    localparam int DATA_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_IN,
        CMP_MAX,
        CMP_MIN,
        DONE
    } state_t;

    // One-hot comparator result codes (a relative to b).
    localparam logic [2:0] CMP_GT = 3'b100;
    localparam logic [2:0] CMP_EQ = 3'b010;
    localparam logic [2:0] CMP_LT = 3'b001;

endpackage

// File: rtl/minmax_scan_ctrl_if.sv
// Bus bundle for the min/max scan engine: burst start, sample stream and result.
//
// Handshake rules, for both the sample stream (in_valid/in_ready) and the
// result (res_valid/res_ready): a transfer happens on a rising clock edge where
// both valid and ready are high. The side that owns valid must keep valid and
// its data stable until that edge. Ready may be high or low independently of
// valid. The engine holds res_valid and the result fields stable until taken.
interface minmax_scan_ctrl_if #(
    parameter int LEN_W = 4
);
    import minmax_pkg::*;

    logic              start;
    logic [LEN_W-1:0]  len;
    logic              busy;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] max_val;
    logic [LEN_W-1:0]  max_idx;
    logic [DATA_W-1:0] min_val;
    logic [LEN_W-1:0]  min_idx;
    logic              res_empty;

    // Sample source / result consumer side.
    modport master (
        output start, len, in_valid, in_data, res_ready,
        input  busy, in_ready, res_valid, max_val, max_idx, min_val, min_idx, res_empty
    );

    // Engine side.
    modport slave (
        input  start, len, in_valid, in_data, res_ready,
        output busy, in_ready, res_valid, max_val, max_idx, min_val, min_idx, res_empty
    );

endinterface

// File: rtl/comparator_4bits.sv
// Unsigned 4-bit magnitude comparator with a one-hot gt/eq/lt result.
module comparator_4bits
    import minmax_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [2:0]        y
);

    // Purely combinational compare; exactly one bit of y is set.
    always_comb begin
        y = CMP_EQ;
        if (a > b) begin
            y = CMP_GT;
        end else if (a < b) begin
            y = CMP_LT;
        end
    end

endmodule

// File: rtl/minmax_scan_ctrl.sv
// Sequential min/max search over a burst of unsigned samples, sharing one
// comparator between the max check and the min check of each sample.
module minmax_scan_ctrl
    import minmax_pkg::*;
#(
    parameter int LEN_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    minmax_scan_ctrl_if.slave  bus,
    output state_t             o_dbg_state
);

    state_t             r_state;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_cnt;
    logic [DATA_W-1:0]  r_data;
    logic [DATA_W-1:0]  r_max_val;
    logic [LEN_W-1:0]   r_max_idx;
    logic [DATA_W-1:0]  r_min_val;
    logic [LEN_W-1:0]   r_min_idx;
    logic               r_res_empty;
    logic               r_busy;
    logic               r_in_ready;
    logic               r_res_valid;

    logic [DATA_W-1:0]  w_cmp_b;
    logic [2:0]         w_cmp_y;
    logic [LEN_W-1:0]   w_cnt_inc;

    // Operand b follows the state: running min during CMP_MIN, running max otherwise.
    assign w_cmp_b   = (r_state == CMP_MIN) ? r_min_val : r_max_val;
    // cnt is always below len, so this increment never wraps.
    assign w_cnt_inc = r_cnt + LEN_W'(1);

    comparator_4bits u_cmp (
        .a (r_data),
        .b (w_cmp_b),
        .y (w_cmp_y)
    );

    // Control FSM with datapath registers; handshake flags are registered
    // alongside every state change so they always match the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_len       <= '0;
            r_cnt       <= '0;
            r_data      <= '0;
            r_max_val   <= '0;
            r_max_idx   <= '0;
            r_min_val   <= '0;
            r_min_idx   <= '0;
            r_res_empty <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b0;
            r_res_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_len       <= bus.len;
                        r_cnt       <= '0;
                        r_res_empty <= 1'b0;
                        r_busy      <= 1'b1;
                        if (bus.len == '0) begin
                            r_res_empty <= 1'b1;
                            r_max_val   <= '0;
                            r_max_idx   <= '0;
                            r_min_val   <= '0;
                            r_min_idx   <= '0;
                            r_res_valid <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_in_ready  <= 1'b1;
                            r_state     <= WAIT_IN;
                        end
                    end
                end
                WAIT_IN: begin
                    if (bus.in_valid) begin
                        r_data <= bus.in_data;
                        if (r_cnt == '0) begin
                            // First sample seeds both extrema at index 0.
                            r_max_val <= bus.in_data;
                            r_min_val <= bus.in_data;
                            r_max_idx <= '0;
                            r_min_idx <= '0;
                            r_cnt     <= LEN_W'(1);
                            if (r_len == LEN_W'(1)) begin
                                r_in_ready  <= 1'b0;
                                r_res_valid <= 1'b1;
                                r_state     <= DONE;
                            end
                        end else begin
                            r_in_ready <= 1'b0;
                            r_state    <= CMP_MAX;
                        end
                    end
                end
                CMP_MAX: begin
                    // Strictly greater only: ties keep the earlier index.
                    if (w_cmp_y == CMP_GT) begin
                        r_max_val <= r_data;
                        r_max_idx <= r_cnt;
                    end
                    r_state <= CMP_MIN;
                end
                CMP_MIN: begin
                    if (w_cmp_y == CMP_LT) begin
                        r_min_val <= r_data;
                        r_min_idx <= r_cnt;
                    end
                    r_cnt <= w_cnt_inc;
                    if (w_cnt_inc == r_len) begin
                        r_res_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_in_ready  <= 1'b1;
                        r_state     <= WAIT_IN;
                    end
                end
                DONE: begin
                    // A start arriving together with res_ready is left for IDLE.
                    if (bus.res_ready) begin
                        r_res_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_busy      <= 1'b0;
                    r_in_ready  <= 1'b0;
                    r_res_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.in_ready  = r_in_ready;
    assign bus.res_valid = r_res_valid;
    assign bus.max_val   = r_max_val;
    assign bus.max_idx   = r_max_idx;
    assign bus.min_val   = r_min_val;
    assign bus.min_idx   = r_min_idx;
    assign bus.res_empty = r_res_empty;
    assign o_dbg_state   = r_state;

endmodule

// File: doc/minmax_scan_ctrl.md
Name: minmax_scan_ctrl

Overview:
Sequential min/max search engine. Accepts a burst of 4-bit samples over a valid/ready stream and time-multiplexes a single 4-bit magnitude comparator, checking each sample first against the running max and then against the running min. Returns max/min values and their first-occurrence indices through a held result handshake. Sits between a sample source and any consumer needing extrema, for example threshold or auto-range logic.

Parameters:
LEN_W, 4, width of burst length and index fields; burst length range 0..2^LEN_W-1.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  reset, asynchronous assert, active-low.
start  in  1  begin a burst; sampled only in IDLE.
len  in  LEN_W  burst length, captured with start.
busy  out  1  high in every state except IDLE.
in_valid  in  1  sample valid.
in_data  in  4  sample, unsigned.
in_ready  out  1  high only in WAIT_IN.
res_valid  out  1  result valid; high only in DONE.
res_ready  in  1  consumer accepts result.
max_val  out  4  largest sample.
max_idx  out  LEN_W  index of first occurrence of max.
min_val  out  4  smallest sample.
min_idx  out  LEN_W  index of first occurrence of min.
res_empty  out  1  burst had len=0.

Behaviour:
- Reset (rst_n low, async): state IDLE; all outputs and internal registers (cnt, len_reg, data_reg) are 0.
- Reset mid-burst aborts the burst. No res_valid is produced; engine is back in IDLE after release.
- States: IDLE, WAIT_IN, CMP_MAX, CMP_MIN, DONE.
- IDLE: start=1 captures len, clears cnt and res_empty.
  - len=0: go to DONE with res_empty=1, max/min/idx=0.
  - Otherwise go to WAIT_IN.
- WAIT_IN: in_ready=1. A transfer occurs when in_valid and in_ready are both high; in_data is latched into data_reg.
  - cnt=0 (first sample): max_val=min_val=in_data, max_idx=min_idx=0, cnt=1. If len=1, go to DONE; else stay in WAIT_IN.
  - cnt>0: go to CMP_MAX.
- CMP_MAX: comparator a=data_reg, b=max_val. On gt (one-hot 100), load max_val=data_reg and max_idx=cnt. Go to CMP_MIN.
- CMP_MIN: comparator a=data_reg, b=min_val. On lt (001), load min_val=data_reg and min_idx=cnt. cnt increments.
  - If cnt+1==len, go to DONE; else go to WAIT_IN.
- DONE: res_valid=1. On res_ready, go to IDLE the same edge.
- Ties (eq, 010) never update, so the earliest index wins.
- Comparator operand b is muxed by state: max_val in CMP_MAX, min_val in CMP_MIN. Comparator output is combinational and consumed in the same cycle; no extra latency.
- Timing:
  - Sample accepted at edge t with cnt>0: res_valid (if last) visible after edge t+2.
  - First sample with len=1: DONE after edge t.
  - Throughput: 1 sample per 3 cycles after the first.
- Result outputs are registered and hold their values through DONE and IDLE until the next accepted start.
- Ignored inputs: start in any state other than IDLE; in_valid outside WAIT_IN (no transfer, in_ready=0).
- Simultaneous start and res_ready in DONE: only the res_ready is taken. start is seen next cycle in IDLE.
- Data is unsigned 4-bit throughout; no arithmetic beyond the LEN_W-bit cnt increment, which never wraps because cnt<len.

Decomposition:
- Package minmax_pkg: DATA_W=4; state enum (IDLE, WAIT_IN, CMP_MAX, CMP_MIN, DONE); comparator result codes CMP_GT=3'b100, CMP_EQ=3'b010, CMP_LT=3'b001.
- Sub-module: exactly one instance of the existing comparator_4bits (a, b 4-bit; y one-hot gt/eq/lt), shared by the CMP_MAX and CMP_MIN states.

Test Plan:
- len=4, samples 3,9,1,9, in_valid held high -> max_val=9, max_idx=1 (tie keeps first), min_val=1, min_idx=2, res_empty=0.
- len=1, sample 7 accepted at edge t -> res_valid after edge t, max=min=7, both idx=0.
- len=0 with start at edge 0 -> res_valid after edge 0, res_empty=1, max/min/idx=0, in_ready never high.
- len=15, samples 0..14 back-to-back, start at edge 0 -> max=14/idx14, min=0/idx0, res_valid first high after edge 43.
- Backpressure: in_valid toggles every other cycle and res_ready is held low 5 cycles in DONE -> correct result; outputs stable; start pulses ignored; busy=1 until the res_ready edge.
- rst_n pulsed low during CMP_MIN of a len=4 burst -> all outputs 0 immediately, no res_valid; a following len=2 burst of 5,2 gives max=5/idx0, min=2/idx1.
